// File: rtl/bellman_relax_pkg.sv
// Shared types, vertex-word helpers and the saturating weight adder used by
// the relaxation and cycle-detection stages.
package bellman_relax_pkg;

  localparam int NODES        = 4;
  localparam int WEIGHT_WIDTH = 7;
  localparam int PRED_WIDTH   = 1;
  localparam int VERT_WIDTH   = WEIGHT_WIDTH + PRED_WIDTH + 2;

  typedef logic signed [WEIGHT_WIDTH:0]   weight_t;
  typedef logic signed [WEIGHT_WIDTH+1:0] wide_t;
  typedef logic        [PRED_WIDTH:0]     idx_t;
  typedef logic        [VERT_WIDTH:0]     vert_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ADDR,
    ST_WAIT,
    ST_EVAL,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam weight_t W_MIN = {1'b1, {WEIGHT_WIDTH{1'b0}}};
  localparam weight_t W_MAX = {1'b0, {WEIGHT_WIDTH{1'b1}}};

  // The cycle flag is always packed as 0 by the relaxation stage.
  function automatic vert_t vert_pack(input idx_t pred, input weight_t w);
    return {1'b0, pred, w};
  endfunction

  function automatic wide_t wide_add(input weight_t a, input weight_t b);
    return wide_t'(a) + wide_t'(b);
  endfunction

  // One guard bit is enough: the sum of two weights never overflows wide_t.
  function automatic weight_t sat_weight(input wide_t s);
    if (s[WEIGHT_WIDTH+1] != s[WEIGHT_WIDTH]) begin
      return s[WEIGHT_WIDTH+1] ? W_MIN : W_MAX;
    end
    return s[WEIGHT_WIDTH:0];
  endfunction

  function automatic weight_t sat_add(input weight_t a, input weight_t b);
    return sat_weight(wide_add(a, b));
  endfunction

endpackage

// File: rtl/bellman_relax_if.sv
// Memory-side bus of the relaxation stage: vertex matrix (two ports) and
// adjacency matrix read port.
interface bellman_relax_if;
  import bellman_relax_pkg::*;

  vert_t   vertmat_q_a;
  vert_t   vertmat_q_b;
  weight_t adjmat_q;
  idx_t    vertmat_addr_a;
  idx_t    vertmat_addr_b;
  vert_t   vertmat_data_b;
  logic    vertmat_we_b;
  idx_t    adjmat_row_addr;
  idx_t    adjmat_col_addr;

  modport master (
    input  vertmat_q_a, vertmat_q_b, adjmat_q,
    output vertmat_addr_a, vertmat_addr_b, vertmat_data_b, vertmat_we_b,
           adjmat_row_addr, adjmat_col_addr
  );

  modport slave (
    output vertmat_q_a, vertmat_q_b, adjmat_q,
    input  vertmat_addr_a, vertmat_addr_b, vertmat_data_b, vertmat_we_b,
           adjmat_row_addr, adjmat_col_addr
  );

endinterface

// File: rtl/bellman_relax_eval.sv
// Combinational relaxation test: compares source weight plus edge against the
// destination weight and produces the saturated candidate.
module bellman_relax_eval
  import bellman_relax_pkg::*;
(
  input  weight_t svw,
  input  weight_t dvw,
  input  weight_t edge_w,
  output logic    update,
  output weight_t new_weight
);

  wide_t sum;

  // The comparison uses the unsaturated sum so a clipped result still
  // counts as an improvement when the true value is below the destination.
  assign sum        = wide_add(svw, edge_w);
  assign update     = (edge_w != '0) && (sum < wide_t'(dvw));
  assign new_weight = sat_weight(sum);

endmodule

// File: rtl/bellman_relax.sv
// Bellman-Ford relaxation sequencer: initialises every vertex to a zero
// source, then sweeps all edges for up to NODES-1 passes with early exit.
module bellman_relax
  import bellman_relax_pkg::*;
(
  input  logic            clk,
  input  logic            relax_reset_n,
  input  logic            relax_start,
  bellman_relax_if.master mem,
  output logic            relax_busy,
  output logic            relax_done,
  output idx_t            relax_passes
);

  localparam idx_t LAST = idx_t'(NODES - 1);

  state_t  state_reg, state_next;
  idx_t    i_reg, i_next;
  idx_t    j_reg, j_next;
  idx_t    passes_reg, passes_next;
  logic    changed_reg, changed_next;

  weight_t svw, dvw, edge_w, new_weight;
  idx_t    passes_inc;
  logic    update;
  logic    unused_fields;

  assign svw           = mem.vertmat_q_a[WEIGHT_WIDTH:0];
  assign dvw           = mem.vertmat_q_b[WEIGHT_WIDTH:0];
  assign edge_w        = mem.adjmat_q;
  assign unused_fields = ^{mem.vertmat_q_a[VERT_WIDTH:WEIGHT_WIDTH+1],
                           mem.vertmat_q_b[VERT_WIDTH:WEIGHT_WIDTH+1]};
  assign passes_inc    = passes_reg + 1'b1;
  assign relax_passes  = passes_reg;

  bellman_relax_eval u_eval (
    .svw        (svw),
    .dvw        (dvw),
    .edge_w     (edge_w),
    .update     (update),
    .new_weight (new_weight)
  );

  always_ff @(posedge clk) begin
    if (!relax_reset_n) begin
      state_reg   <= ST_IDLE;
      i_reg       <= '0;
      j_reg       <= '0;
      passes_reg  <= '0;
      changed_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      i_reg       <= i_next;
      j_reg       <= j_next;
      passes_reg  <= passes_next;
      changed_reg <= changed_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    i_next       = i_reg;
    j_next       = j_reg;
    passes_next  = passes_reg;
    changed_next = changed_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (relax_start) begin
          state_next   = ST_INIT;
          i_next       = '0;
          j_next       = '0;
          passes_next  = '0;
          changed_next = 1'b0;
        end
      end
      // j doubles as the vertex counter while initialising.
      ST_INIT: begin
        if (j_reg == LAST) begin
          state_next = ST_ADDR;
          i_next     = '0;
          j_next     = '0;
        end else begin
          j_next = j_reg + 1'b1;
        end
      end
      ST_ADDR: state_next = (i_reg == j_reg) ? ST_NEXT : ST_WAIT;
      ST_WAIT: state_next = ST_EVAL;
      ST_EVAL: begin
        state_next = ST_NEXT;
        if (update) begin
          changed_next = 1'b1;
        end
      end
      ST_NEXT: begin
        state_next = ST_ADDR;
        if (j_reg != LAST) begin
          j_next = j_reg + 1'b1;
        end else if (i_reg != LAST) begin
          j_next = '0;
          i_next = i_reg + 1'b1;
        end else begin
          j_next      = '0;
          i_next      = '0;
          passes_next = passes_inc;
          if (passes_inc == LAST || !changed_reg) begin
            state_next = ST_DONE;
          end else begin
            changed_next = 1'b0;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.vertmat_addr_a  = '0;
    mem.vertmat_addr_b  = '0;
    mem.vertmat_data_b  = '0;
    mem.vertmat_we_b    = 1'b0;
    mem.adjmat_row_addr = '0;
    mem.adjmat_col_addr = '0;
    relax_busy          = 1'b0;
    relax_done          = 1'b0;
    case (state_reg)
      ST_INIT: begin
        mem.vertmat_addr_b = j_reg;
        mem.vertmat_data_b = vert_pack(j_reg, '0);
        mem.vertmat_we_b   = 1'b1;
        relax_busy         = 1'b1;
      end
      ST_ADDR, ST_WAIT, ST_EVAL, ST_NEXT: begin
        mem.vertmat_addr_a  = i_reg;
        mem.vertmat_addr_b  = j_reg;
        mem.adjmat_row_addr = i_reg;
        mem.adjmat_col_addr = j_reg;
        relax_busy          = 1'b1;
        if (state_reg == ST_EVAL) begin
          mem.vertmat_we_b   = update;
          mem.vertmat_data_b = vert_pack(i_reg, new_weight);
        end
      end
      ST_DONE: relax_done = 1'b1;
      default: ;
    endcase
  end

endmodule
